// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held in END until start_i drops.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  // state   | meaning
  // FREE    | idle, waiting for start_i
  // BY_ZERO | divisor was zero, result forced to 0
  // ON      | iterating, one quotient bit per cycle
  // END     | result valid, held while start_i stays high
  localparam logic [1:0] S_FREE    = 2'd0;
  localparam logic [1:0] S_BY_ZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] w_q, w_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2, quot, rem;
  logic [33:0] diff;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    mag1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    // Extra top bit makes the borrow of the 33-bit subtraction visible.
    diff = {1'b0, w_q[64:32]} - {2'b00, divisor_q};
    quot = (signed_q && (sign1_q ^ sign2_q)) ? -w_q[31:0] : w_q[31:0];
    rem  = (signed_q && sign1_q) ? -w_q[64:33] : w_q[64:33];

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = S_BY_ZERO;
          end else begin
            state_d   = S_ON;
            divisor_d = mag2;
            w_d       = {32'd0, mag1, 1'b0};
            cnt_d     = 6'd0;
            signed_d  = signed_div_i;
            sign1_d   = opdata1_i[31];
            sign2_d   = opdata2_i[31];
          end
        end
      end
      S_BY_ZERO: begin
        state_d  = S_END;
        result_d = 64'd0;
        ready_d  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q == 6'd32) begin
          state_d  = S_END;
          result_d = {rem, quot};
          ready_d  = 1'b1;
        end else begin
          if (diff[33]) w_d = {w_q[63:0], 1'b0};
          else          w_d = {diff[31:0], w_q[31:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= 6'd0;
      w_q       <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands checked against a plain-arithmetic division model.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_err = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q  = x / y;
    r  = x % y;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Starts an operation at the current negedge and holds start_i until ready_o.
  // lat = number of edges after E0 at which ready_o was first seen (-1 if never).
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output logic [63:0] res, output int lat);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    res          = 64'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        lat = k;
        res = result_o;
        break;
      end
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got=%b exp=0", ready_o);
    end
    n_cmp++;
    if (result_o !== 64'd0) begin
      n_err++; $display("FAIL reset_result got=%h exp=0", result_o);
    end
    start_i = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic        s_t[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t[8]  = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h1234, 32'h1234,
                             32'hFFFFFFFF, 32'h80000000, 32'd5};
    logic [31:0] b_t[8]  = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0,
                             32'd1, 32'hFFFFFFFF, 32'd9};
    logic [63:0] ex_t[8] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD},
                             {32'd1, 32'hFFFFFFFD}, 64'd0, 64'd0,
                             {32'd0, 32'hFFFFFFFF}, {32'd0, 32'h80000000},
                             {32'd5, 32'd0}};
    logic [63:0] res;
    int lat, exp_lat;
    for (int i = 0; i < 8; i++) begin
      exp_lat = (b_t[i] == 32'd0) ? 1 : 33;
      run_op(s_t[i], a_t[i], b_t[i], 1'b0, res, lat);
      n_cmp++;
      if (lat != exp_lat) begin
        n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat);
      end
      n_cmp++;
      if (res !== ex_t[i]) begin
        n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, ex_t[i]);
      end
      n_cmp++;
      if (res !== ref_div(s_t[i], a_t[i], b_t[i])) begin
        n_err++; $display("FAIL dir%0d_model got=%h exp=%h", i, res,
                          ref_div(s_t[i], a_t[i], b_t[i]));
      end
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b1 || result_o !== ex_t[i]) begin
        n_err++; $display("FAIL dir%0d_hold got=%b/%h exp=1/%h", i, ready_o, result_o, ex_t[i]);
      end
      start_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        n_err++; $display("FAIL dir%0d_release got=%b/%h exp=0/0", i, ready_o, result_o);
      end
    end
  endtask

  task automatic test_random;
    logic s;
    logic [31:0] a, b;
    logic [63:0] res, exp_res;
    int lat, exp_lat;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp_res = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      run_op(s, a, b, 1'b0, res, lat);
      n_cmp++;
      if (lat != exp_lat || res !== exp_res) begin
        n_err++;
        $display("FAIL rand%0d s=%b a=%h b=%h got=%h@%0d exp=%h@%0d", i, s, a, b,
                 res, lat, exp_res, exp_lat);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_annul;
    logic [63:0] res;
    int lat, rises;
    int at_t[2] = '{10, 32};
    for (int j = 0; j < 2; j++) begin
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 1; k < at_t[j]; k++) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      rises = 0;
      for (int k = 0; k < 40; k++) begin
        if (ready_o !== 1'b0) rises++;
        @(negedge clk);
      end
      n_cmp++;
      if (rises != 0) begin
        n_err++; $display("FAIL annul_at_%0d ready_high_cycles got=%0d exp=0", at_t[j], rises);
      end
      run_op(1'b0, 32'd100, 32'd7, 1'b0, res, lat);
      n_cmp++;
      if (lat != 33 || res !== {32'd2, 32'd14}) begin
        n_err++; $display("FAIL after_annul_%0d got=%h@%0d exp=%h@33", at_t[j], res, lat,
                          {32'd2, 32'd14});
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid;
    logic [63:0] res;
    int lat, rises;
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF00; opdata2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_err++; $display("FAIL rst_mid got=%b/%h exp=0/0", ready_o, result_o);
    end
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o !== 1'b0) rises++;
      @(negedge clk);
    end
    n_cmp++;
    if (rises != 0) begin
      n_err++; $display("FAIL rst_mid_ready_high_cycles got=%0d exp=0", rises);
    end
    run_op(1'b1, 32'hFFFFFF00, 32'd3, 1'b0, res, lat);
    n_cmp++;
    if (lat != 33 || res !== ref_div(1'b1, 32'hFFFFFF00, 32'd3)) begin
      n_err++; $display("FAIL after_rst got=%h@%0d exp=%h@33", res, lat,
                        ref_div(1'b1, 32'hFFFFFF00, 32'd3));
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operand_change;
    logic s;
    logic [31:0] a, b;
    logic [63:0] res, exp_res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 0) ? 32'd7 : ($urandom | 32'd1);
      exp_res = ref_div(s, a, b);
      run_op(s, a, b, 1'b1, res, lat);
      n_cmp++;
      if (lat != 33 || res !== exp_res) begin
        n_err++; $display("FAIL opchange%0d got=%h@%0d exp=%h@33", i, res, lat, exp_res);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic s;
    logic [31:0] a, b;
    logic [63:0] res, exp_res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom_range(1, 1000);
      exp_res = ref_div(s, a, b);
      run_op(s, a, b, 1'b0, res, lat);
      n_cmp++;
      if (lat != 33 || res !== exp_res) begin
        n_err++; $display("FAIL b2b%0d got=%h@%0d exp=%h@33", i, res, lat, exp_res);
      end
      start_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b0) begin
        n_err++; $display("FAIL b2b%0d_gap_ready got=%b exp=0", i, ready_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    test_reset;
    test_directed;
    test_random;
    test_annul;
    test_rst_mid;
    test_operand_change;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
